// File: rtl/lbist_pkg.sv
// Shared types and combinational helpers for the logic-BIST controller.
package lbist_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCapture,
    StUnload,
    StCompare,
    StDone
  } lbist_state_e;

  typedef enum logic {
    ModePrpg,
    ModeMisr
  } lfsr_mode_e;

  // Scan-in bit for chain i: three PRPG taps spread across the register.
  function automatic logic phase_shift(input logic [MaxW-1:0] prpg, input int unsigned i,
                                       input int unsigned w);
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] c;
    a = 6'(i % w);
    b = 6'((7 * i + 3) % w);
    c = 6'((13 * i + 5) % w);
    return prpg[a] ^ prpg[b] ^ prpg[c];
  endfunction

  // Bit j of the folded scan-out word: XOR of every chain landing on position j.
  function automatic logic misr_fold(input logic [MaxW-1:0] so, input int unsigned j,
                                     input int unsigned n_chains, input int unsigned w);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i < n_chains && (i % w) == j) r = r ^ so[i[5:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/lbist_ctrl_if.sv
// Control, status and scan signals between the BIST controller and the core under test.
interface lbist_ctrl_if #(
  parameter int unsigned N_CHAINS = 20,
  parameter int unsigned MISR_W   = 32
);
  logic                test_normal_i;
  logic                start_i;
  logic                pi_i;
  logic [MISR_W-1:0]   golden_sig_i;
  logic [N_CHAINS-1:0] scan_out_i;
  logic [N_CHAINS-1:0] scan_in_o;
  logic                test_en_o;
  logic                muxed_pi_o;
  logic                bist_active_o;
  logic                done_o;
  logic                go_nogo_o;
  logic [MISR_W-1:0]   signature_o;

  modport master (
    input  test_normal_i, start_i, pi_i, golden_sig_i, scan_out_i,
    output scan_in_o, test_en_o, muxed_pi_o, bist_active_o, done_o, go_nogo_o, signature_o
  );

  modport slave (
    output test_normal_i, start_i, pi_i, golden_sig_i, scan_out_i,
    input  scan_in_o, test_en_o, muxed_pi_o, bist_active_o, done_o, go_nogo_o, signature_o
  );
endinterface

// File: rtl/lbist_lfsr.sv
// Galois shift register used both as pattern generator and as signature register.
module lbist_lfsr
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter lfsr_mode_e       MODE  = ModePrpg
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] Init = (MODE == ModePrpg) ? SEED : '0;

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = Init;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0) ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= Init;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: PRPG-driven scan shift/capture, MISR compaction, signature compare.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned       N_CHAINS   = 20,
  parameter int unsigned       CHAIN_LEN  = 64,
  parameter int unsigned       N_PATTERNS = 1024,
  parameter int unsigned       PRPG_W     = 32,
  parameter logic [PRPG_W-1:0] PRPG_POLY  = 32'h8020_0003,
  parameter logic [PRPG_W-1:0] PRPG_SEED  = 32'h1,
  parameter int unsigned       MISR_W     = 32,
  parameter logic [MISR_W-1:0] MISR_POLY  = 32'h04C1_1DB7
) (
  input logic         clk_i,
  input logic         rst_ni,
  lbist_ctrl_if.master bus
);

  localparam int unsigned ShW  = $clog2(CHAIN_LEN);
  localparam int unsigned PatW = $clog2(N_PATTERNS + 1);
  localparam logic [ShW-1:0]  ShLast  = ShW'(CHAIN_LEN - 1);
  localparam logic [PatW-1:0] PatLast = PatW'(N_PATTERNS - 1);

  lbist_state_e      state_q, state_d;
  logic [ShW-1:0]    sh_cnt_q, sh_cnt_d;
  logic [PatW-1:0]   pat_cnt_q, pat_cnt_d;
  logic              go_nogo_q, go_nogo_d;
  logic [MISR_W-1:0] sig_q, sig_d;

  logic                lfsr_load, prpg_en, misr_en;
  logic [PRPG_W-1:0]   prpg;
  logic [MISR_W-1:0]   misr;
  logic [MISR_W-1:0]   fold_vec;
  logic [N_CHAINS-1:0] ps_vec;
  logic [MaxW-1:0]     prpg_ext, so_ext;

  assign prpg_ext = MaxW'(prpg);
  assign so_ext   = MaxW'(bus.scan_out_i);

  always_comb begin
    ps_vec   = '0;
    fold_vec = '0;
    for (int unsigned i = 0; i < N_CHAINS; i++) ps_vec[i] = phase_shift(prpg_ext, i, PRPG_W);
    for (int unsigned j = 0; j < MISR_W; j++) begin
      fold_vec[j] = misr_fold(so_ext, j, N_CHAINS, MISR_W);
    end
  end

  lbist_lfsr #(
    .WIDTH(PRPG_W),
    .POLY (PRPG_POLY),
    .SEED (PRPG_SEED),
    .MODE (ModePrpg)
  ) u_prpg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (prpg_en),
    .load  (lfsr_load),
    .data_i('0),
    .q     (prpg)
  );

  lbist_lfsr #(
    .WIDTH(MISR_W),
    .POLY (MISR_POLY),
    .SEED ('0),
    .MODE (ModeMisr)
  ) u_misr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (misr_en),
    .load  (lfsr_load),
    .data_i(fold_vec),
    .q     (misr)
  );

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    pat_cnt_d = pat_cnt_q;
    go_nogo_d = go_nogo_q;
    sig_d     = sig_q;
    lfsr_load = 1'b0;
    prpg_en   = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i && !bus.test_normal_i) begin
          state_d   = StShift;
          lfsr_load = 1'b1;
          sh_cnt_d  = '0;
          pat_cnt_d = '0;
          go_nogo_d = 1'b0;
          sig_d     = '0;
        end
      end
      StShift: begin
        prpg_en  = 1'b1;
        // Pattern 0 unloads the unknown post-reset chain contents, so keep them out.
        misr_en  = (pat_cnt_q != '0);
        sh_cnt_d = sh_cnt_q + 1'b1;
        if (sh_cnt_q == ShLast) begin
          sh_cnt_d = '0;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        pat_cnt_d = pat_cnt_q + 1'b1;
        state_d   = (pat_cnt_q == PatLast) ? StUnload : StShift;
      end
      StUnload: begin
        misr_en  = 1'b1;
        sh_cnt_d = sh_cnt_q + 1'b1;
        if (sh_cnt_q == ShLast) begin
          sh_cnt_d = '0;
          state_d  = StCompare;
        end
      end
      StCompare: begin
        go_nogo_d = (misr == bus.golden_sig_i);
        sig_d     = misr;
        state_d   = StDone;
      end
      StDone: begin
        if (!bus.start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.test_normal_i &&
        state_q inside {StShift, StCapture, StUnload, StCompare}) begin
      state_d   = StIdle;
      sh_cnt_d  = '0;
      pat_cnt_d = '0;
      go_nogo_d = 1'b0;
      prpg_en   = 1'b0;
      misr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sh_cnt_q  <= '0;
      pat_cnt_q <= '0;
      go_nogo_q <= 1'b0;
      sig_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      go_nogo_q <= go_nogo_d;
      sig_q     <= sig_d;
    end
  end

  assign bus.test_en_o     = (state_q == StShift) || (state_q == StUnload);
  assign bus.scan_in_o     = (state_q == StShift) ? ps_vec : '0;
  assign bus.bist_active_o = !(state_q inside {StIdle, StDone});
  assign bus.done_o        = (state_q == StDone);
  assign bus.muxed_pi_o    = (state_q inside {StIdle, StDone}) ? bus.pi_i : prpg[PRPG_W-1];
  assign bus.go_nogo_o     = go_nogo_q;
  assign bus.signature_o   = sig_q;

endmodule
